// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the 4-digit 7-segment scan driver
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'hF;

  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] IDX_MIN1 = 2'd0;
  localparam logic [IDX_W-1:0] IDX_MIN2 = 2'd1;
  localparam logic [IDX_W-1:0] IDX_HR1  = 2'd2;
  localparam logic [IDX_W-1:0] IDX_HR2  = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD to active-low {g..a} segment pattern, blank above 9
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed HH.MM display driver with per-frame digit snapshot
// Optional LEADING_ZERO_BLANK_EN blanks the hours-tens digit when it is zero.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min1,
  input  logic [3:0] min2,
  input  logic [3:0] hr1,
  input  logic [3:0] hr2,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      samp_q;
  logic [15:0]      snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;

  logic [15:0] live;
  logic        slot_end;
  logic        frame_start;
  logic [3:0]  cur_digit;
  logic [6:0]  dec_seg;

  assign live = {hr2, hr1, min2, min1};

  seg7_decode u_decode (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    slot_end    = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_start = slot_end && (idx_q == IDX_HR2);
    div_cnt_d   = slot_end ? '0 : div_cnt_q + 1'b1;
    idx_d       = slot_end ? idx_q + 1'b1 : idx_q;
    // Inputs cross from the slow timer domain: only accept them when two consecutive samples agree.
    snap_d      = (frame_start && (samp_q == live)) ? samp_q : snap_q;
    cur_digit   = snap_q[{idx_q, 2'b00} +: 4];

    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (div_cnt_q >= CNT_W'(BLANK_CYCLES)) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = dec_seg;
      dp_d  = (idx_q != IDX_HR1);
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx_q == IDX_HR2) && (snap_q[15:12] == 4'd0)) begin
        seg_d = SEG_BLANK;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= IDX_MIN1;
      samp_q    <= '0;
      snap_q    <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      samp_q    <= live;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench with a cycle-time reference model of the scan driver
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] min1 = 4'd4, min2 = 4'd3, hr1 = 4'd2, hr2 = 4'd1;
  wire  [6:0] seg;
  wire  [3:0] an;
  wire        dp;

  int checks = 0;
  int errors = 0;

  logic [6:0] cap_seg [4];
  int         cnt_an [4];
  int         cnt_blank;
  int         cnt_dp;
  logic [3:0] dp_an;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk  (clk),
    .rst  (rst),
    .min1 (min1),
    .min2 (min2),
    .hr1  (hr1),
    .hr2  (hr2),
    .seg  (seg),
    .an   (an),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 4'd9) return 7'h7F;
    return tbl[d];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time index t since reset release gives slot and position directly.
  initial begin : model_chk
    int t;
    int div;
    int idx;
    logic [15:0] m_snap, m_prev, live;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_dp;
    t = 0;
    m_snap = '0;
    m_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        t = 0; m_snap = '0; m_prev = '0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        live = {hr2, hr1, min2, min1};
        div  = t % RD;
        idx  = (t / RD) % 4;
        if (div < BC) begin
          e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          e_an  = 4'hF & ~(4'b0001 << idx);
          e_seg = dec(m_snap[idx*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
          if (idx == 3 && m_snap[15:12] == 4'd0) e_seg = 7'h7F;
`endif
          e_dp  = (idx != 2);
        end
        if (div == RD - 1 && idx == 3 && m_prev == live) m_snap = m_prev;
        m_prev = live;
        t++;
        case (an)
          4'hE: begin cap_seg[0] = seg; cnt_an[0]++; end
          4'hD: begin cap_seg[1] = seg; cnt_an[1]++; end
          4'hB: begin cap_seg[2] = seg; cnt_an[2]++; end
          4'h7: begin cap_seg[3] = seg; cnt_an[3]++; end
          4'hF: cnt_blank++;
          default: ;
        endcase
        if (dp == 1'b0) begin cnt_dp++; dp_an = an; end
      end
      check("scan", {20'd0, an, seg, dp}, {20'd0, e_an, e_seg, e_dp});
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic run_frames(input int n);
    run_cycles(n * FRAME);
  endtask

  task automatic clear_caps();
    for (int i = 0; i < 4; i++) begin
      cap_seg[i] = 7'h55;
      cnt_an[i]  = 0;
    end
    cnt_blank = 0;
    cnt_dp    = 0;
    dp_an     = 4'h0;
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check({name, "_blank"}, {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    clear_caps();
    run_cycles(3);
    rst = 1'b0;
    run_cycles(13);
    async_reset("rst_mid");

    clear_caps();
    run_frames(1);
    for (int i = 0; i < 4; i++) check("first_frame_zero", {25'd0, cap_seg[i]}, 32'h40);

    clear_caps();
    run_frames(1);
    check("f1_min1", {25'd0, cap_seg[0]}, 32'h19);
    check("f1_min2", {25'd0, cap_seg[1]}, 32'h30);
    check("f1_hr1",  {25'd0, cap_seg[2]}, 32'h24);
    check("f1_hr2",  {25'd0, cap_seg[3]}, 32'h79);
    for (int i = 0; i < 4; i++) check("slot_width", cnt_an[i], 6);
    check("blank_width", cnt_blank, 4 * BC);
    check("dp_count", cnt_dp, 6);
    check("dp_anode", {28'd0, dp_an}, 32'hB);

    clear_caps();
    run_cycles(16);
    min1 = 4'd7;
    run_cycles(16);
    check("midframe_keep", {25'd0, cap_seg[0]}, 32'h19);
    clear_caps();
    run_frames(1);
    check("midframe_next", {25'd0, cap_seg[0]}, 32'h78);

    run_cycles(FRAME - 1);
    min1 = 4'd5;
    run_cycles(1);
    clear_caps();
    run_frames(1);
    check("edge_toggle_hold", {25'd0, cap_seg[0]}, 32'h78);
    clear_caps();
    run_frames(1);
    check("edge_toggle_land", {25'd0, cap_seg[0]}, 32'h12);

    min2 = 4'hA;
    run_frames(1);
    clear_caps();
    run_frames(1);
    check("bad_bcd_blank", {25'd0, cap_seg[1]}, 32'h7F);
    check("bad_bcd_anode", cnt_an[1], 6);
    check("bad_bcd_other", {25'd0, cap_seg[0]}, 32'h12);
    check("bad_bcd_hr1",   {25'd0, cap_seg[2]}, 32'h24);

    hr2 = 4'd0;
    hr1 = 4'd9;
    run_frames(1);
    clear_caps();
    run_frames(1);
`ifdef LEADING_ZERO_BLANK_EN
    check("hr2_zero", {25'd0, cap_seg[3]}, 32'h7F);
`else
    check("hr2_zero", {25'd0, cap_seg[3]}, 32'h40);
`endif
    check("hr2_zero_anode", cnt_an[3], 6);
    check("hr1_nine", {25'd0, cap_seg[2]}, 32'h10);

    for (int k = 0; k < 40; k++) begin
      run_cycles($urandom_range(1, 90));
      if ($urandom_range(0, 3) == 0) begin
        min1 = 4'($urandom_range(0, 15));
        min2 = 4'($urandom_range(0, 15));
        hr1  = 4'($urandom_range(0, 15));
        hr2  = 4'($urandom_range(0, 15));
      end else begin
        min1 = 4'($urandom_range(0, 9));
      end
    end

    async_reset("rst_end");
    run_frames(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
